// File: rtl/dn_result_fifo.sv
// Result FIFO between the delay-estimation core (dn) and the SPI serialiser; flushed on every head_flag rising edge.
// Optional `DN_RESULT_FIFO_TAG_EN adds a per-entry 4-bit frame tag on dout_tag.
module dn_result_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             head_flag,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             rd_req,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count,
    output logic             ovf,
    output logic             udf,
    output logic             dbg_state
`ifdef DN_RESULT_FIFO_TAG_EN
    ,output logic [3:0]      dout_tag
`endif
);

    // Handshake: din_valid is a one-cycle push qualifier with no backpressure (drops set ovf);
    // rd_req pops when not empty and the word appears with a dout_valid pulse one cycle later.
    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_head_q;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [AW:0]      w_count_nxt;
    logic             r_empty;
    logic             r_full;
    logic             r_ovf;
    logic             r_udf;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_head_rise;
    logic             w_run;
    logic             w_wr;
    logic             w_rd;
    logic             w_mem_we;
    logic [AW-1:0]    w_mem_addr;

    assign w_head_rise = head_flag & ~r_head_q;
    // A flush cycle overrides normal traffic, so RUN-mode reads/writes are masked by the rising edge.
    assign w_run       = (r_state == S_RUN) & ~w_head_rise;
    assign w_rd        = w_run & rd_req & ~r_empty;
    assign w_wr        = w_run & din_valid & (~r_full | rd_req);
    assign w_mem_we    = w_head_rise ? din_valid : w_wr;
    assign w_mem_addr  = w_head_rise ? '0 : r_wr_ptr;

    always_comb begin
        w_state_nxt = r_state;
        if (w_head_rise) begin
            w_state_nxt = S_RUN;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_head_rise) begin
            w_count_nxt = din_valid ? CNT_ONE : '0;
        end else if (w_wr && !w_rd) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (w_rd && !w_wr) begin
            w_count_nxt = r_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_head_q     <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_empty      <= 1'b1;
            r_full       <= 1'b0;
            r_ovf        <= 1'b0;
            r_udf        <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_head_q     <= head_flag;
            r_count      <= w_count_nxt;
            r_empty      <= (w_count_nxt == '0);
            r_full       <= (w_count_nxt == CNT_FULL);
            r_dout_valid <= w_rd;
            if (w_rd) begin
                r_dout <= r_mem[r_rd_ptr];
            end
            if (w_head_rise) begin
                r_wr_ptr <= din_valid ? PTR_ONE : '0;
                r_rd_ptr <= '0;
                r_ovf    <= 1'b0;
                r_udf    <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
                if (w_rd) begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                end
                if (w_run && din_valid && r_full && !rd_req) begin
                    r_ovf <= 1'b1;
                end
                if (w_run && rd_req && r_empty) begin
                    r_udf <= 1'b1;
                end
            end
        end
    end

`ifdef DN_RESULT_FIFO_TAG_EN
    logic [3:0] r_frame;
    logic [3:0] r_tag_out;
    logic [3:0] r_tag_mem [DEPTH];
    logic [3:0] w_frame_nxt;

    assign w_frame_nxt = w_head_rise ? (r_frame + 4'd1) : r_frame;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_tag_mem[w_mem_addr] <= w_frame_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame   <= 4'd0;
            r_tag_out <= 4'd0;
        end else begin
            r_frame <= w_frame_nxt;
            if (w_rd) begin
                r_tag_out <= r_tag_mem[r_rd_ptr];
            end
        end
    end

    assign dout_tag = r_tag_out;
`endif

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign empty      = r_empty;
    assign full       = r_full;
    assign count      = r_count;
    assign ovf        = r_ovf;
    assign udf        = r_udf;
    assign dbg_state  = r_state;

endmodule
